// File: rtl/hora_proto_pkg.sv
// Time-frame byte protocol definitions shared by the transmit and receive sides.
// Optional: ENVIAR_HORA_CHECKSUM_EN adds the checksum state and helper.
package hora_proto_pkg;

  localparam logic [7:0]        DELIM_CHAR   = 8'd90;
  localparam int                N_BYTES      = 6;
  localparam int                HORA_W       = 8 * N_BYTES;
  localparam logic [HORA_W-1:0] HORA_DEFAULT = 48'h303030303030;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_SOF   = 3'd2,
    ST_DATA  = 3'd3,
    ST_EOF   = 3'd4,
    ST_GAP   = 3'd5,
    ST_FIN   = 3'd6
`ifdef ENVIAR_HORA_CHECKSUM_EN
    , ST_CSUM = 3'd7
`endif
  } state_e;

  // A payload byte may never be NUL or look like a frame delimiter.
  function automatic logic is_legal_byte(input logic [7:0] b);
    is_legal_byte = (b != 8'h00) && (b != DELIM_CHAR);
  endfunction

`ifdef ENVIAR_HORA_CHECKSUM_EN
  // XOR of all payload bytes with bit 7 forced so it can never be NUL or 'Z'.
  function automatic logic [7:0] frame_checksum(input logic [HORA_W-1:0] w);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < N_BYTES; i++) begin
      acc = acc ^ w[8*i +: 8];
    end
    frame_checksum = acc | 8'h80;
  endfunction
`endif

endpackage

// File: rtl/gap_timer.sv
// Inter-byte gap timer: loaded on each accepted byte, counts down, flags
// expiry once GAP_CYCLES-1 gap cycles have elapsed since the load.
module gap_timer #(
  parameter int GAP_CYCLES = 100_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expired
);

  localparam int CNT_W = $clog2(GAP_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(GAP_CYCLES - 1);

  logic [CNT_W-1:0] cnt_r;

  // Count-down register, reloaded on every accepted byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= LOAD_VAL;
    end else if (cnt_r != {CNT_W{1'b0}}) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Last gap cycle when the count reaches one; a zero load (GAP_CYCLES=1)
  // still yields a single gap cycle so tx_valid always drops after a transfer.
  assign expired = (cnt_r <= CNT_W'(1));

endmodule

// File: rtl/enviar_hora.sv
// Time-frame transmitter: latches a time word on start and sends
// 'Z', payload bytes, 'Z' to the UART TX with a minimum inter-byte gap.
// Optional: ENVIAR_HORA_CHECKSUM_EN inserts a checksum byte before the closing 'Z'.
module enviar_hora
  import hora_proto_pkg::*;
#(
  parameter logic [7:0] DELIM      = DELIM_CHAR,
  parameter int         N_BYTES    = hora_proto_pkg::N_BYTES,
  parameter int         GAP_CYCLES = 100_000
) (
  input  logic                 clk,
  input  logic                 init,
  input  logic [8*N_BYTES-1:0] hora,
  input  logic                 start,
  input  logic                 tx_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  output logic                 busy,
  output logic                 DONE,
  output logic                 err
);

  localparam int IDX_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

  logic                 init_meta_r, rst_n_r;
  state_e               state_r, state_nxt_s, ret_r, ret_nxt_s;
  logic [IDX_W-1:0]     idx_r, idx_nxt_s;
  logic [8*N_BYTES-1:0] latched_r;
  logic                 latch_s, gap_load_s, gap_expired_s, hs_s, illegal_s;
  logic [7:0]           tx_data_r, tx_data_nxt_s;
  logic                 tx_valid_r, tx_valid_nxt_s;
  logic                 busy_r, busy_nxt_s, done_r, done_nxt_s, err_r, err_nxt_s;

  assign hs_s     = tx_valid_r & tx_ready;
  assign tx_data  = tx_data_r;
  assign tx_valid = tx_valid_r;
  assign busy     = busy_r;
  assign DONE     = done_r;
  assign err      = err_r;

  // Reset synchroniser: asserts immediately with init, releases two clocks later.
  always_ff @(posedge clk or negedge init) begin
    if (!init) begin
      init_meta_r <= 1'b0;
      rst_n_r     <= 1'b0;
    end else begin
      init_meta_r <= 1'b1;
      rst_n_r     <= init_meta_r;
    end
  end

  gap_timer #(.GAP_CYCLES(GAP_CYCLES)) u_gap (
    .clk     (clk),
    .rst_n   (rst_n_r),
    .load    (gap_load_s),
    .expired (gap_expired_s)
  );

  // Flag a latched word that contains any byte the receiver would misread.
  always_comb begin
    illegal_s = 1'b0;
    for (int i = 0; i < N_BYTES; i++) begin
      if (!is_legal_byte(latched_r[8*i +: 8]) || (latched_r[8*i +: 8] == DELIM)) begin
        illegal_s = 1'b1;
      end else begin
        illegal_s = illegal_s;
      end
    end
  end

  // Next-state logic: frame sequencing, byte index and gap return state.
  always_comb begin
    state_nxt_s = state_r;
    ret_nxt_s   = ret_r;
    idx_nxt_s   = idx_r;
    latch_s     = 1'b0;
    gap_load_s  = 1'b0;
    err_nxt_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_CHECK;
          latch_s     = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (illegal_s) begin
          state_nxt_s = ST_IDLE;
          err_nxt_s   = 1'b1;
        end else begin
          state_nxt_s = ST_SOF;
        end
      end
      ST_SOF: begin
        if (hs_s) begin
          state_nxt_s = ST_GAP;
          ret_nxt_s   = ST_DATA;
          idx_nxt_s   = {IDX_W{1'b0}};
          gap_load_s  = 1'b1;
        end else begin
          state_nxt_s = ST_SOF;
        end
      end
      ST_DATA: begin
        if (hs_s) begin
          state_nxt_s = ST_GAP;
          gap_load_s  = 1'b1;
          if (idx_r == LAST_IDX) begin
            idx_nxt_s = {IDX_W{1'b0}};
`ifdef ENVIAR_HORA_CHECKSUM_EN
            ret_nxt_s = ST_CSUM;
`else
            ret_nxt_s = ST_EOF;
`endif
          end else begin
            idx_nxt_s = idx_r + IDX_W'(1);
            ret_nxt_s = ST_DATA;
          end
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
`ifdef ENVIAR_HORA_CHECKSUM_EN
      ST_CSUM: begin
        if (hs_s) begin
          state_nxt_s = ST_GAP;
          ret_nxt_s   = ST_EOF;
          gap_load_s  = 1'b1;
        end else begin
          state_nxt_s = ST_CSUM;
        end
      end
`endif
      ST_EOF: begin
        if (hs_s) begin
          state_nxt_s = ST_FIN;
        end else begin
          state_nxt_s = ST_EOF;
        end
      end
      ST_GAP: begin
        if (gap_expired_s) begin
          state_nxt_s = ret_r;
        end else begin
          state_nxt_s = ST_GAP;
        end
      end
      ST_FIN: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    tx_valid_nxt_s = 1'b0;
    tx_data_nxt_s  = 8'h00;
    busy_nxt_s     = 1'b1;
    done_nxt_s     = 1'b0;
    case (state_nxt_s)
      ST_IDLE: begin
        busy_nxt_s = 1'b0;
      end
      ST_SOF, ST_EOF: begin
        tx_valid_nxt_s = 1'b1;
        tx_data_nxt_s  = DELIM;
      end
      ST_DATA: begin
        tx_valid_nxt_s = 1'b1;
        tx_data_nxt_s  = latched_r[8*idx_nxt_s +: 8];
      end
`ifdef ENVIAR_HORA_CHECKSUM_EN
      ST_CSUM: begin
        tx_valid_nxt_s = 1'b1;
        tx_data_nxt_s  = frame_checksum(latched_r);
      end
`endif
      ST_FIN: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b1;
      end
      default: begin
        busy_nxt_s = 1'b1;
      end
    endcase
  end

  // State, payload latch and registered outputs.
  always_ff @(posedge clk or negedge rst_n_r) begin
    if (!rst_n_r) begin
      state_r    <= ST_IDLE;
      ret_r      <= ST_IDLE;
      idx_r      <= {IDX_W{1'b0}};
      latched_r  <= {N_BYTES{HORA_DEFAULT[7:0]}};
      tx_valid_r <= 1'b0;
      tx_data_r  <= 8'h00;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      ret_r      <= ret_nxt_s;
      idx_r      <= idx_nxt_s;
      if (latch_s) begin
        latched_r <= hora;
      end else begin
        latched_r <= latched_r;
      end
      tx_valid_r <= tx_valid_nxt_s;
      tx_data_r  <= tx_data_nxt_s;
      busy_r     <= busy_nxt_s;
      done_r     <= done_nxt_s;
      err_r      <= err_nxt_s;
    end
  end

endmodule
